dac_spi_ctrl: RTL and testbench



---
 rtl/dac_spi_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_dac_spi_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_ctrl.sv
// Sample FIFO feeding a fixed-rate 16-bit SPI DAC serialiser with underrun detection.
// Build option: define DAC_UNDERRUN_MUTE_EN to send midscale instead of repeating the last sample on underrun.
module dac_spi_ctrl #(
    parameter int          SCLK_DIV   = 2,
    parameter int          SAMPLE_DIV = 80,
    parameter int          FIFO_AW    = 2,
    parameter logic [3:0]  CTRL_BITS  = 4'b0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [7:0]         s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic               dac_sclk,
    output logic               dac_din,
    output logic               dac_cs_n,
    output logic               busy,
    output logic               underrun,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(SAMPLE_DIV);
    localparam int HW    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    localparam logic [TW-1:0]      TICK_AT     = TW'(SAMPLE_DIV - 1);
    localparam logic [TW-1:0]      TMR_ZERO    = {TW{1'b0}};
    localparam logic [HW-1:0]      HALF_END    = HW'(SCLK_DIV - 1);
    localparam logic [HW-1:0]      HALF_ZERO   = {HW{1'b0}};
    localparam logic [FIFO_AW:0]   LEVEL_EMPTY = {(FIFO_AW+1){1'b0}};
    localparam logic [FIFO_AW:0]   LEVEL_FULL  = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW-1:0] PTR_ZERO    = {FIFO_AW{1'b0}};
    localparam logic [7:0]         MIDSCALE    = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CS_SETUP = 2'd1,
        ST_SHIFT    = 2'd2,
        ST_CS_HOLD  = 2'd3
    } state_t;

    logic [7:0]         mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [FIFO_AW:0]   level_r;
    logic [FIFO_AW:0]   level_nxt_s;
    logic               s_ready_r;

    logic [TW-1:0]      tmr_r;
    logic               tick_s;
    logic               start_s;
    logic               fifo_empty_s;
    logic               push_s;
    logic               pop_s;
    logic [7:0]         head_s;
    logic [7:0]         sample_s;
    logic [15:0]        frame_s;

    state_t             state_r;
    logic [15:0]        shift_r;
    logic [HW-1:0]      half_r;
    logic               high_r;
    logic [3:0]         bit_r;
    logic [7:0]         last_r;
    logic               sclk_r;
    logic               din_r;
    logic               cs_n_r;
    logic               busy_r;
    logic               underrun_r;

    // Handshake, tick qualification and next-frame selection; emptiness is judged before any same-cycle push
    always_comb begin
        push_s       = s_valid && s_ready_r;
        tick_s       = enable && (tmr_r == TICK_AT);
        start_s      = tick_s && (state_r == ST_IDLE);
        fifo_empty_s = (level_r == LEVEL_EMPTY);
        head_s       = mem_r[rd_ptr_r];
        if (start_s && !fifo_empty_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (!fifo_empty_s) begin
            sample_s = head_s;
        end else begin
`ifdef DAC_UNDERRUN_MUTE_EN
            sample_s = MIDSCALE;
`else
            sample_s = last_r;
`endif
        end
        frame_s = {CTRL_BITS, sample_s, 4'b0000};
    end

    // Next FIFO occupancy from the push/pop pair
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + {{FIFO_AW{1'b0}}, 1'b1};
            2'b01:   level_nxt_s = level_r - {{FIFO_AW{1'b0}}, 1'b1};
            default: level_nxt_s = level_r;
        endcase
    end

    // Sample-rate timer: free-runs while enabled, parked at zero otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_r <= TMR_ZERO;
        end else if (!enable) begin
            tmr_r <= TMR_ZERO;
        end else if (tmr_r == TICK_AT) begin
            tmr_r <= TMR_ZERO;
        end else begin
            tmr_r <= tmr_r + TW'(1);
        end
    end

    // FIFO storage; contents need no reset because pointers and level define validity
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= s_data;
        end
    end

    // FIFO pointers, level and the registered ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r  <= PTR_ZERO;
            rd_ptr_r  <= PTR_ZERO;
            level_r   <= LEVEL_EMPTY;
            s_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
            end
            level_r   <= level_nxt_s;
            s_ready_r <= (level_nxt_s != LEVEL_FULL);
        end
    end

    // Frame sequencer with registered SPI pins, busy and underrun pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            shift_r    <= 16'h0000;
            half_r     <= HALF_ZERO;
            high_r     <= 1'b0;
            bit_r      <= 4'd0;
            last_r     <= MIDSCALE;
            sclk_r     <= 1'b0;
            din_r      <= 1'b0;
            cs_n_r     <= 1'b1;
            busy_r     <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        shift_r    <= frame_s;
                        din_r      <= frame_s[15];
                        cs_n_r     <= 1'b0;
                        sclk_r     <= 1'b0;
                        busy_r     <= 1'b1;
                        underrun_r <= fifo_empty_s;
                        if (!fifo_empty_s) begin
                            last_r <= head_s;
                        end
                        state_r    <= ST_CS_SETUP;
                    end else begin
                        cs_n_r <= 1'b1;
                        din_r  <= 1'b0;
                        sclk_r <= 1'b0;
                        busy_r <= 1'b0;
                    end
                end
                ST_CS_SETUP: begin
                    din_r   <= shift_r[15];
                    half_r  <= HALF_ZERO;
                    high_r  <= 1'b0;
                    bit_r   <= 4'd0;
                    state_r <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (half_r == HALF_END) begin
                        half_r <= HALF_ZERO;
                        if (!high_r) begin
                            sclk_r <= 1'b1;
                            high_r <= 1'b1;
                        end else if (bit_r == 4'd15) begin
                            sclk_r  <= 1'b0;
                            high_r  <= 1'b0;
                            state_r <= ST_CS_HOLD;
                        end else begin
                            // falling edge: advance to the next bit
                            sclk_r  <= 1'b0;
                            high_r  <= 1'b0;
                            shift_r <= {shift_r[14:0], 1'b0};
                            din_r   <= shift_r[14];
                            bit_r   <= bit_r + 4'd1;
                        end
                    end else begin
                        half_r <= half_r + HW'(1);
                    end
                end
                ST_CS_HOLD: begin
                    cs_n_r  <= 1'b1;
                    din_r   <= 1'b0;
                    sclk_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    cs_n_r  <= 1'b1;
                    din_r   <= 1'b0;
                    sclk_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready    = s_ready_r;
    assign fifo_level = level_r;
    assign dac_sclk   = sclk_r;
    assign dac_din    = din_r;
    assign dac_cs_n   = cs_n_r;
    assign busy       = busy_r;
    assign underrun   = underrun_r;

endmodule

// File: tb/tb_dac_spi_ctrl.sv
// Directed bench for dac_spi_ctrl: expected SPI frames are queued at stimulus time and
// compared when the monitor captures a complete chip-select window.
module tb_dac_spi_ctrl;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       dac_sclk;
    logic       dac_din;
    logic       dac_cs_n;
    logic       busy;
    logic       underrun;
    logic [2:0] fifo_level;

    int tests = 0;
    int fails = 0;
    int frames_done = 0;
    int ur_cnt = 0;
    logic [15:0] exp_q[$];

    dac_spi_ctrl dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .dac_sclk(dac_sclk), .dac_din(dac_din), .dac_cs_n(dac_cs_n),
        .busy(busy), .underrun(underrun), .fifo_level(fifo_level)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frame capture: shift in dac_din at each sclk rise while cs_n is low
    logic [15:0] bits;
    int          nbits = 0;
    int          lowcnt = 0;
    logic        in_frame = 1'b0;
    logic        prev_sclk = 1'b0;
    logic        prev_ur = 1'b0;
    logic [15:0] exp_f;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_frame  = 1'b0;
            nbits     = 0;
            lowcnt    = 0;
            prev_sclk = 1'b0;
            prev_ur   = 1'b0;
        end else begin
            if (!dac_cs_n) begin
                lowcnt++;
                in_frame = 1'b1;
                if (dac_sclk && !prev_sclk) begin
                    bits = {bits[14:0], dac_din};
                    nbits++;
                end
            end else if (in_frame) begin
                chk("cs_low_cycles", lowcnt, 66);
                chk("sclk_rises", nbits, 16);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL frame_unexpected: observed 0x%0h expected none", bits);
                end else begin
                    exp_f = exp_q.pop_front();
                    chk("frame", bits, exp_f);
                end
                frames_done++;
                in_frame = 1'b0;
                lowcnt   = 0;
                nbits    = 0;
            end
            if (underrun && !prev_ur) ur_cnt++;
            prev_ur   = underrun;
            prev_sclk = dac_sclk;
        end
    end

    task automatic wait_busy_rise(output int cyc);
        logic pb;
        pb  = busy;
        cyc = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (busy && !pb) begin
                cyc = i;
                return;
            end
            pb = busy;
        end
        tests++;
        fails++;
        $error("FAIL busy_timeout: observed no frame start, expected one within 400 cycles");
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < 600; i++) begin
            if (frames_done >= n) return;
            @(negedge clk);
        end
        tests++;
        fails++;
        $error("FAIL frame_timeout: observed %0d frames expected %0d", frames_done, n);
    endtask

    task automatic push_one(input logic [7:0] d);
        s_data  = d;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        int ur0;
        int nb;
        rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_sclk", dac_sclk, 0);
        chk("rst_din", dac_din, 0);
        chk("rst_cs_n", dac_cs_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", s_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty FIFO: first tick underruns with the reset last-sample
        exp_q.push_back(16'h0800);
        enable = 1'b1;
        wait_busy_rise(cyc);
        chk("t1_tick_cycle", cyc, 80);
        chk("t1_underrun", underrun, 1);
        @(negedge clk);
        chk("t1_underrun_width", underrun, 0);
        wait_frames(1);
        enable = 1'b0;
        chk("t1_ur_count", ur_cnt, 1);

        // Single sample A5
        push_one(8'hA5);
        exp_q.push_back(16'h0A50);
        chk("t2_level_pre", fifo_level, 1);
        enable = 1'b1;
        wait_busy_rise(cyc);
        chk("t2_tick_cycle", cyc, 80);
        chk("t2_level_post", fifo_level, 0);
        chk("t2_underrun", underrun, 0);
        wait_frames(2);
        enable = 1'b0;

        // Fill the FIFO, stall a fifth sample
        s_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            s_data = 8'(k);
            exp_q.push_back({4'h0, 8'(k), 4'h0});
            @(negedge clk);
        end
        chk("t3_ready_full", s_ready, 0);
        chk("t3_level_full", fifo_level, 4);
        s_data = 8'h05;
        repeat (3) @(negedge clk);
        chk("t3_level_stall", fifo_level, 4);
        s_valid = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_busy_rise(cyc);
            chk("t3_spacing", cyc, 80);
        end
        // Drop enable mid-frame: frame must still complete, then silence
        repeat (20) @(negedge clk);
        enable = 1'b0;
        wait_frames(6);
        chk("t3_level_drained", fifo_level, 0);
        ur0 = ur_cnt;
        nb  = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) nb++;
        end
        chk("t5_no_busy", nb, 0);
        chk("t5_no_underrun", ur_cnt, ur0);

        // One sample then starvation
        push_one(8'h3C);
        exp_q.push_back(16'h03C0);
`ifdef DAC_UNDERRUN_MUTE_EN
        exp_q.push_back(16'h0800);
`else
        exp_q.push_back(16'h03C0);
`endif
        enable = 1'b1;
        wait_busy_rise(cyc);
        chk("t4_tick1", cyc, 80);
        chk("t4_underrun1", underrun, 0);
        wait_busy_rise(cyc);
        chk("t4_tick2", cyc, 80);
        chk("t4_underrun2", underrun, 1);
        wait_frames(8);
        enable = 1'b0;
        chk("t4_ur_count", ur_cnt, ur0 + 1);

        // Reset in the middle of bit 7
        push_one(8'h55);
        push_one(8'h66);
        enable = 1'b1;
        wait_busy_rise(cyc);
        chk("t6_tick", cyc, 80);
        repeat (31) @(negedge clk);
        chk("t6_busy_mid", busy, 1);
        chk("t6_level_mid", fifo_level, 1);
        #2;
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        chk("t6_cs_n", dac_cs_n, 1);
        chk("t6_sclk", dac_sclk, 0);
        chk("t6_din", dac_din, 0);
        chk("t6_busy", busy, 0);
        chk("t6_level", fifo_level, 0);
        chk("t6_ready", s_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back(16'h0800);
        enable = 1'b1;
        wait_busy_rise(cyc);
        chk("t6_tick_after_rst", cyc, 80);
        chk("t6_underrun_after_rst", underrun, 1);
        wait_frames(9);
        enable = 1'b0;
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
